// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce_press block.
package debounce_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_DOWN,
        S_DISARM
    } db_state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sat_timer.sv
// Saturating up-counter with clear priority over enable.
// done flags the count sitting at MAX; hit flags that the coming edge lands on MAX.
module sat_timer
    import debounce_pkg::*;
#(
    parameter int MAX = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic done,
    output logic hit
);

    localparam int W = cnt_w(MAX);
    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] PRE_V = W'(MAX - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != MAX_V)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign done = (cnt == MAX_V);
    assign hit  = en && !clr && (cnt == PRE_V);

endmodule

// File: rtl/debounce_press.sv
// Debouncer producing a clean level plus press/release pulses; the long-press
// pulse is built only when DEBOUNCE_PRESS_LONG_PRESS_EN is defined.
//
//   state    | meaning
//   S_IDLE   | debounced low, input low
//   S_ARM    | debounced low, input high, counting towards acceptance
//   S_DOWN   | debounced high, input high
//   S_DISARM | debounced high, input low, counting towards acceptance
module debounce_press
    import debounce_pkg::*;
#(
    parameter int DB_CYCLES   = 50000,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic x,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic long_press
);

    db_state_t state, state_nxt;
    logic      db_clr, db_en, db_done, db_hit_unused;
    logic      press_nxt, release_nxt, level_nxt;

    sat_timer #(.MAX(DB_CYCLES)) u_db_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (db_clr),
        .en      (db_en),
        .done    (db_done),
        .hit     (db_hit_unused)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            level         <= level_nxt;
            press         <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

    // Any disagreeing sample clears the window, so a bounce restarts the count.
    always_comb begin
        state_nxt   = state;
        db_clr      = 1'b0;
        db_en       = 1'b0;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (x) begin
                    state_nxt = S_ARM;
                    db_en     = 1'b1;
                end
            end
            S_ARM: begin
                if (!x) begin
                    state_nxt = S_IDLE;
                    db_clr    = 1'b1;
                end else if (db_done) begin
                    state_nxt = S_DOWN;
                    press_nxt = 1'b1;
                    db_clr    = 1'b1;
                end else begin
                    db_en = 1'b1;
                end
            end
            S_DOWN: begin
                if (!x) begin
                    state_nxt = S_DISARM;
                    db_en     = 1'b1;
                end
            end
            S_DISARM: begin
                if (x) begin
                    state_nxt = S_DOWN;
                    db_clr    = 1'b1;
                end else if (db_done) begin
                    state_nxt   = S_IDLE;
                    release_nxt = 1'b1;
                    db_clr      = 1'b1;
                end else begin
                    db_en = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                db_clr    = 1'b1;
            end
        endcase
        level_nxt = (state_nxt == S_DOWN) || (state_nxt == S_DISARM);
    end

`ifdef DEBOUNCE_PRESS_LONG_PRESS_EN
    logic hold_clr, hold_en, hold_hit, hold_done_unused;

    // Hold time keeps running through a release bounce; only a fresh press or idle clears it.
    assign hold_clr = press_nxt || (state_nxt == S_IDLE);
    assign hold_en  = (state == S_DOWN) || (state == S_DISARM);

    sat_timer #(.MAX(HOLD_CYCLES)) u_hold_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (hold_clr),
        .en      (hold_en),
        .done    (hold_done_unused),
        .hit     (hold_hit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            long_press <= 1'b0;
        end else begin
            long_press <= hold_hit;
        end
    end
`else
    localparam int unused_hold_cycles = HOLD_CYCLES;
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_press.sv
// Scoreboard bench for debounce_press with DB_CYCLES=4, HOLD_CYCLES=10; long-press
// expectations follow DEBOUNCE_PRESS_LONG_PRESS_EN.
module tb_debounce_press;

    localparam int DB   = 4;
    localparam int HOLD = 10;
`ifdef DEBOUNCE_PRESS_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n;
    logic x;
    logic level, press, release_pulse, long_press;

    int  ecnt   = 0;
    int  n_vec  = 0;
    int  n_miss = 0;
    ev_t sb[$];

    debounce_press #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .x             (x),
        .level         (level),
        .press         (press),
        .release_pulse (release_pulse),
        .long_press    (long_press)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic push(input int kind, input int cyc);
        ev_t e;
        e.kind = kind;
        e.cyc  = cyc;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_level(input logic exp, input string name);
        n_vec++;
        if (level !== exp) begin
            n_miss++;
            $display("FAIL %s: level=%b expected %b at edge %0d", name, level, exp, ecnt);
        end
    endtask

    task automatic check_pulses_low(input string name);
        n_vec++;
        if ({press, release_pulse, long_press} !== 3'b000) begin
            n_miss++;
            $display("FAIL %s: pulses=%b expected 000", name, {press, release_pulse, long_press});
        end
    endtask

    task automatic check_pulse(input int kind);
        ev_t  e;
        logic lvl_exp;
        n_vec++;
        if (sb.size() == 0) begin
            n_miss++;
            $display("FAIL unexpected_pulse: kind=%0d at edge %0d, expected none", kind, ecnt);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.cyc != ecnt) begin
                n_miss++;
                $display("FAIL pulse_event: kind=%0d edge=%0d, expected kind=%0d edge=%0d",
                         kind, ecnt, e.kind, e.cyc);
            end
        end
        if (kind != K_LONG) begin
            lvl_exp = (kind == K_PRESS);
            n_vec++;
            if (level !== lvl_exp) begin
                n_miss++;
                $display("FAIL level_with_pulse: level=%b expected %b at edge %0d", level, lvl_exp, ecnt);
            end
        end
    endtask

    // Monitor: every pulse the DUT shows is matched against the scoreboard.
    always @(negedge clk) begin
        if (press && release_pulse) begin
            n_vec++;
            n_miss++;
            $display("FAIL press_and_release: both high at edge %0d, expected exclusive", ecnt);
        end
        if (press)         check_pulse(K_PRESS);
        if (release_pulse) check_pulse(K_RELEASE);
        if (long_press)    check_pulse(K_LONG);
    end

    // x high for hi sampled edges then low for lo edges.
    task automatic run_press(input int hi, input int lo, input string name);
        int k, p, r;
        k = ecnt + 1;
        x = 1'b1;
        if (hi > DB) begin
            p = k + DB;
            r = k + hi;
            push(K_PRESS, p);
            if (LP_EN && (p + HOLD < r + DB)) push(K_LONG, p + HOLD);
            push(K_RELEASE, r + DB);
        end
        tick(hi);
        check_level(hi > DB, {name, "_held"});
        x = 1'b0;
        tick(lo);
        check_level(1'b0, {name, "_after"});
    endtask

    initial begin
        int k;
        reset_n = 1'b0;
        x       = 1'b1;
        tick(3);
        check_level(1'b0, "in_reset");
        check_pulses_low("in_reset_pulses");

        // Reset exit with x already high: full debounce before press.
        reset_n = 1'b1;
        k = ecnt + 1;
        push(K_PRESS, k + DB);
        tick(DB);
        check_level(1'b0, "reset_exit_pre");
        tick(1);
        check_level(1'b1, "reset_exit_post");
        tick(5);
        x = 1'b0;
        push(K_RELEASE, k + 10 + DB);
        tick(8);
        check_level(1'b0, "reset_exit_release");

        run_press(20, 8, "clean");
        run_press(DB, 8, "window_short");
        run_press(DB + 1, 8, "window_exact");

        x = 1'b1; tick(3);
        x = 1'b0; tick(1);
        x = 1'b1; tick(3);
        x = 1'b0; tick(6);
        check_level(1'b0, "bounce");

        // Release glitch: two low samples inside the release window.
        k = ecnt + 1;
        x = 1'b1;
        push(K_PRESS, k + DB);
        tick(6);
        x = 1'b0; tick(2);
        x = 1'b1; tick(6);
        check_level(1'b1, "release_glitch");
        x = 1'b0;
        if (LP_EN) push(K_LONG, k + DB + HOLD);
        push(K_RELEASE, k + 14 + DB);
        tick(8);
        check_level(1'b0, "release_glitch_after");

        run_press(30, 8, "long_hold");
        run_press(8, 8, "short_hold");

        // Reset mid-count (ARM, count 3), then mid-hold.
        k = ecnt + 1;
        x = 1'b1;
        tick(3);
        reset_n = 1'b0;
        #1;
        check_level(1'b0, "midcount_reset");
        check_pulses_low("midcount_reset_pulses");
        tick(2);
        reset_n = 1'b1;
        k = ecnt + 1;
        push(K_PRESS, k + DB);
        tick(DB);
        check_level(1'b0, "midcount_pre");
        tick(1);
        check_level(1'b1, "midcount_post");
        tick(2);
        reset_n = 1'b0;
        #1;
        check_level(1'b0, "midhold_reset");
        x = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(8);
        check_level(1'b0, "midhold_after");

        tick(20);
        n_vec++;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: %0d pulses missing, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/debounce_press.md
Name: debounce_press

Overview:
- Consumes the 2-flop-synchronised button/sensor level produced by the upstream synchroniser stage.
- Debounces that level and produces:
  - a clean debounced level;
  - single-cycle press and release pulses;
  - optionally, a long-press pulse.
- Downstream feeder/pet-control FSMs consume the pulses directly and never see raw contact bounce.

Parameters:
- DB_CYCLES, 50000, clock edges the input must stay stable before a level change is accepted (1 ms at 50 MHz); legal range ≥1.
- HOLD_CYCLES, 50000000, clock edges in the debounced-high state before long_press fires (1 s at 50 MHz); legal range ≥1; used only with LONG_PRESS_EN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset; synchronous deassertion is guaranteed externally.
- x  in  1  synchronised input, already 2-flop synchronised, active high.
- level  out  1  debounced level.
- press  out  1  one-cycle pulse on accepted 0→1.
- release  out  1  one-cycle pulse on accepted 1→0.
- long_press  out  1  one-cycle pulse after HOLD_CYCLES held high.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=S_IDLE; db_cnt=0; hold_cnt=0.
  - level, press, release and long_press all 0.
- All outputs are registered; no combinational path from x to any output.
- Four-state FSM, state register plus db_cnt of width $clog2(DB_CYCLES+1):
  - S_IDLE (level=0): x=1 sampled → S_ARM, db_cnt=1. Otherwise hold.
  - S_ARM (level=0):
    - x=0 → S_IDLE, db_cnt=0, no pulse.
    - x=1 and db_cnt==DB_CYCLES → S_DOWN, level←1, press←1, db_cnt=0.
    - Otherwise db_cnt++.
  - S_DOWN (level=1): x=0 sampled → S_DISARM, db_cnt=1. Otherwise hold.
  - S_DISARM (level=1):
    - x=1 → S_DOWN, db_cnt=0, no pulse.
    - x=0 and db_cnt==DB_CYCLES → S_IDLE, level←0, release←1, db_cnt=0.
    - Otherwise db_cnt++.
- Latency: if x first samples high at edge k and stays high, level and press are high after edge k+DB_CYCLES. Release is symmetric.
- press and release are high for exactly one cycle; they are never high together. Any bounce inside the window restarts the count from scratch.
- DB_CYCLES=1: a change is accepted after 2 consecutive equal samples, i.e. 1 edge after entry.
- db_cnt never exceeds DB_CYCLES and never wraps.
- Reset asserted mid-count or mid-hold: everything clears immediately. No pulse is emitted on reset exit. If x=1 at reset exit, the block re-debounces and fires press DB_CYCLES edges later.

Optional Feature:
- Macro: DEBOUNCE_PRESS_LONG_PRESS_EN.
- Defined:
  - hold_cnt, width $clog2(HOLD_CYCLES+1), clears on entry to S_DOWN (same edge as press).
  - hold_cnt increments every cycle in S_DOWN or S_DISARM.
  - When hold_cnt reaches HOLD_CYCLES, long_press←1 for one cycle and hold_cnt saturates. At most one long_press per press.
  - hold_cnt clears on return to S_IDLE.
- Undefined: hold_cnt is not instantiated and long_press is tied 0.

Decomposition:
- Package debounce_pkg:
  - state enum typedef db_state_t {S_IDLE, S_ARM, S_DOWN, S_DISARM};
  - localparam function cnt_w(n) returning $clog2(n+1).
- One natural sub-module, sat_timer:
  - Parameter MAX; inputs clk, reset_n, clr, en; output done.
  - Used for db_cnt, and for hold_cnt when the macro is on.

Test Plan (DB_CYCLES=4, HOLD_CYCLES=10 for simulation):
- Reset with x=1 held, release reset_n at edge 0 → press=1 after edge 4 only, level=1 from then. No pulse during reset.
- Clean press: x 0→1 at edge 10, held → press high in cycle after edge 14 only, level 1. x→0 at edge 30 → release pulse after edge 34, level 0.
- Bounce: x=1 for 3 edges, 0 for 1, 1 for 3, 0 → level stays 0 and no press/release ever.
- Release glitch: in S_DOWN, x=0 for 2 edges then 1 → level stays 1, no release and no second press.
- With DEBOUNCE_PRESS_LONG_PRESS_EN:
  - Hold x=1 for 30 edges → press at edge 4 and exactly one long_press at edge 14.
  - Release after 8 held edges → no long_press.
  - Without the macro, long_press stays 0 throughout.
- Mid-count reset: assert reset_n=0 while in S_ARM with db_cnt=3 → outputs 0 immediately. After release with x=1, press occurs a full 4 edges later.
